// File: rtl/alu_op_sequencer.sv
// Multicycle MIPS control FSM: one state per cycle, Moore outputs plus IRWrite/PCEn on MemReady/Zero.
// Memory states wait on MemReady; a wait that hits TIMEOUT_CYCLES aborts the access and returns to FETCH.
module alu_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [1:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSource,
    output logic       PCEn,
    output logic       IllegalOp,
    output logic       MemTimeout,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADDR = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        REXEC   = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        IEXEC   = 4'd10,
        IWB     = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] alu_ctl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_rd;
        logic       mem_wr;
        logic       i_or_d;
        logic       ir_wr;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal;
        logic       timeout;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [5:0] op_reg, funct_reg;
    logic       mem_wait;
    ctl_t       ctl, ctl_out;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            op_reg    <= '0;
            funct_reg <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == DECODE) begin
                op_reg    <= Opcode;
                funct_reg <= Funct;
            end
        end
    end

    always_comb begin
        ctl          = '0;
        state_nxt    = state;
        mem_wait     = 1'b0;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            FETCH: begin
                ctl.mem_rd    = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.alu_ctl   = 2'b10;
                ctl.ir_wr     = MemReady;
                ctl.pc_en     = MemReady;
                mem_wait      = 1'b1;
                if (MemReady) state_nxt = DECODE;
            end
            DECODE: begin
                // Speculative branch target into ALUOut while the opcode is decoded.
                ctl.alu_src_b = 2'b11;
                ctl.alu_ctl   = 2'b10;
                case (Opcode)
                    OP_RTYPE:     state_nxt = REXEC;
                    OP_LW, OP_SW: state_nxt = MEMADDR;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_J:         state_nxt = JUMP;
                    OP_ADDI:      state_nxt = IEXEC;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_nxt   = FETCH;
                    end
                endcase
            end
            MEMADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_ctl   = 2'b10;
                state_nxt     = (op_reg == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctl.mem_rd = 1'b1;
                ctl.i_or_d = 1'b1;
                mem_wait   = 1'b1;
                if (MemReady) state_nxt = MEMWB;
            end
            MEMWB: begin
                ctl.reg_wr     = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_nxt      = FETCH;
            end
            MEMWR: begin
                ctl.mem_wr = 1'b1;
                ctl.i_or_d = 1'b1;
                mem_wait   = 1'b1;
                if (MemReady) state_nxt = FETCH;
            end
            REXEC: begin
                ctl.alu_src_a = 1'b1;
                state_nxt     = RWB;
                case (funct_reg)
                    FN_ADD: ctl.alu_ctl = 2'b10;
                    FN_SUB: ctl.alu_ctl = 2'b11;
                    FN_AND: ctl.alu_ctl = 2'b00;
                    FN_OR:  ctl.alu_ctl = 2'b01;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_nxt   = FETCH;
                    end
                endcase
            end
            RWB: begin
                ctl.reg_wr  = 1'b1;
                ctl.reg_dst = 1'b1;
                state_nxt   = FETCH;
            end
            BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_ctl   = 2'b11;
                ctl.pc_src    = 2'b01;
                ctl.pc_en     = Zero;
                state_nxt     = FETCH;
            end
            JUMP: begin
                ctl.pc_src = 2'b10;
                ctl.pc_en  = 1'b1;
                state_nxt  = FETCH;
            end
            IEXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_ctl   = 2'b10;
                state_nxt     = IWB;
            end
            IWB: begin
                ctl.reg_wr = 1'b1;
                state_nxt  = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        if (mem_wait && !MemReady) begin
            if (wait_cnt == WAIT_LIMIT) begin
                ctl.timeout = 1'b1;
                state_nxt   = FETCH;
            end else begin
                wait_cnt_nxt = wait_cnt + 8'd1;
            end
        end
        // A timed-out fetch re-enters FETCH from itself, so it also restarts the count.
        if (ctl.timeout || ((state_nxt != state) &&
            (state_nxt == FETCH || state_nxt == MEMRD || state_nxt == MEMWR)))
            wait_cnt_nxt = '0;
    end

    assign ctl_out    = Rst_n ? ctl : '0;
    assign ALUControl = ctl_out.alu_ctl;
    assign ALUSrcA    = ctl_out.alu_src_a;
    assign ALUSrcB    = ctl_out.alu_src_b;
    assign MemRead    = ctl_out.mem_rd;
    assign MemWrite   = ctl_out.mem_wr;
    assign IorD       = ctl_out.i_or_d;
    assign IRWrite    = ctl_out.ir_wr;
    assign RegWrite   = ctl_out.reg_wr;
    assign RegDst     = ctl_out.reg_dst;
    assign MemtoReg   = ctl_out.mem_to_reg;
    assign PCSource   = ctl_out.pc_src;
    assign PCEn       = ctl_out.pc_en;
    assign IllegalOp  = ctl_out.illegal;
    assign MemTimeout = ctl_out.timeout;
    assign State      = Rst_n ? state : 4'd0;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instruction-level reference traces, table vectors and random instructions.
module tb_alu_op_sequencer;
    localparam int TMO = 4;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [5:0] Opcode, Funct;
    logic       Zero, MemReady;
    logic [1:0] ALUControl, ALUSrcB, PCSource;
    logic       ALUSrcA, MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg;
    logic       PCEn, IllegalOp, MemTimeout;
    logic [3:0] State;

    alu_op_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource),
        .PCEn(PCEn), .IllegalOp(IllegalOp), .MemTimeout(MemTimeout), .State(State)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       mrd, mwr, iord, irw, rw, rdst, m2r;
        logic [1:0] pcs;
        logic       pcen, ill, tmo;
    } obs_t;

    typedef struct { logic mrdy; logic zero; obs_t e; } cyc_t;

    typedef struct packed {
        logic [7:0] nf, irw, rw, pcen, ill, tmo;
        logic [2:0] xalu;
    } cnt_t;

    typedef struct {
        string      name;
        logic [5:0] op, fn;
        logic       zero;
        int         fw, dw;
        cnt_t       exp;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    cyc_t q[$];
    vec_t vq[$];

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic obs_t blank(input int st);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = State;     o.alu = ALUControl; o.srca = ALUSrcA; o.srcb = ALUSrcB;
        o.mrd = MemRead;  o.mwr = MemWrite;   o.iord = IorD;    o.irw = IRWrite;
        o.rw = RegWrite;  o.rdst = RegDst;    o.m2r = MemtoReg; o.pcs = PCSource;
        o.pcen = PCEn;    o.ill = IllegalOp;  o.tmo = MemTimeout;
        return o;
    endfunction

    function automatic cnt_t mk_cnt(input int nf, input int irw, input int rw, input int pcen,
                                    input int ill, input int tmo, input int xalu);
        cnt_t c;
        c.nf = 8'(nf); c.irw = 8'(irw); c.rw = 8'(rw); c.pcen = 8'(pcen);
        c.ill = 8'(ill); c.tmo = 8'(tmo); c.xalu = 3'(xalu);
        return c;
    endfunction

    task automatic chk(input string name, input int idx, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic push(input logic mrdy, input logic zero, input obs_t e);
        cyc_t c;
        c.mrdy = mrdy; c.zero = zero; c.e = e;
        q.push_back(c);
    endtask

    // One memory access: 'waits' cycles of MemReady=0 then ready, unless the limit expires first.
    task automatic mem_phase(input obs_t base, input int waits, input bit is_fetch, output bit ok);
        bit   done;
        obs_t e;
        done = 1'b0;
        ok   = 1'b0;
        for (int k = 0; k <= waits && !done; k++) begin
            e = base;
            if (k == waits) begin
                if (is_fetch) begin e.irw = 1'b1; e.pcen = 1'b1; end
                push(1'b1, rb(), e);
                ok = 1'b1; done = 1'b1;
            end else if (k == TMO) begin
                e.tmo = 1'b1;
                push(1'b0, rb(), e);
                done = 1'b1;
            end else begin
                push(1'b0, rb(), e);
            end
        end
    endtask

    // Reference trace of one instruction, written from the instruction's micro-step recipe.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                         input int fw, input int dw);
        obs_t e;
        bit   ok, legal, fn_ok;
        e = blank(0); e.mrd = 1'b1; e.srcb = 2'b01; e.alu = 2'b10;
        mem_phase(e, fw, 1'b1, ok);
        if (!ok) return;
        e = blank(1); e.srcb = 2'b11; e.alu = 2'b10;
        legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
                (op == 6'h02) || (op == 6'h08);
        e.ill = !legal;
        push(rb(), rb(), e);
        if (!legal) return;
        case (op)
            6'h23, 6'h2B: begin
                e = blank(2); e.srca = 1'b1; e.srcb = 2'b10; e.alu = 2'b10;
                push(rb(), rb(), e);
                if (op == 6'h23) begin
                    e = blank(3); e.mrd = 1'b1; e.iord = 1'b1;
                    mem_phase(e, dw, 1'b0, ok);
                    if (ok) begin
                        e = blank(4); e.rw = 1'b1; e.m2r = 1'b1;
                        push(rb(), rb(), e);
                    end
                end else begin
                    e = blank(5); e.mwr = 1'b1; e.iord = 1'b1;
                    mem_phase(e, dw, 1'b0, ok);
                end
            end
            6'h00: begin
                e = blank(6); e.srca = 1'b1;
                fn_ok = 1'b1;
                case (fn)
                    6'h20: e.alu = 2'b10;
                    6'h22: e.alu = 2'b11;
                    6'h24: e.alu = 2'b00;
                    6'h25: e.alu = 2'b01;
                    default: fn_ok = 1'b0;
                endcase
                e.ill = !fn_ok;
                push(rb(), rb(), e);
                if (fn_ok) begin
                    e = blank(7); e.rw = 1'b1; e.rdst = 1'b1;
                    push(rb(), rb(), e);
                end
            end
            6'h04: begin
                e = blank(8); e.srca = 1'b1; e.alu = 2'b11; e.pcs = 2'b01; e.pcen = zero;
                push(rb(), zero, e);
            end
            6'h02: begin
                e = blank(9); e.pcs = 2'b10; e.pcen = 1'b1;
                push(rb(), rb(), e);
            end
            default: begin
                e = blank(10); e.srca = 1'b1; e.srcb = 2'b10; e.alu = 2'b10;
                push(rb(), rb(), e);
                e = blank(11); e.rw = 1'b1;
                push(rb(), rb(), e);
            end
        endcase
    endtask

    // Applies the queued trace cycle by cycle; entered and left just after a rising edge.
    task automatic run_q(input string name, input logic [5:0] op, input logic [5:0] fn,
                         output cnt_t got);
        obs_t o;
        got = '0;
        for (int i = 0; i < q.size(); i++) begin
            MemReady = q[i].mrdy; Zero = q[i].zero; Opcode = op; Funct = fn;
            @(negedge Clk);
            o = sample();
            chk(name, i, o, q[i].e);
            if (o.st != 4'd0) got.nf   = got.nf + 8'd1;
            if (o.irw)        got.irw  = got.irw + 8'd1;
            if (o.rw)         got.rw   = got.rw + 8'd1;
            if (o.pcen)       got.pcen = got.pcen + 8'd1;
            if (o.ill)        got.ill  = got.ill + 8'd1;
            if (o.tmo)        got.tmo  = got.tmo + 8'd1;
            if (o.st == 4'd6) got.xalu = {1'b1, o.alu};
            @(posedge Clk);
            #1;
        end
        q.delete();
    endtask

    task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input int fw, input int dw, input cnt_t exp);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.zero = zero; v.fw = fw; v.dw = dw; v.exp = exp;
        vq.push_back(v);
    endtask

    initial begin
        cnt_t       got;
        obs_t       e;
        logic [5:0] op, fn;

        // counts: non-FETCH cycles, IRWrite, RegWrite, PCEn, IllegalOp, MemTimeout, {seen REXEC, ALUControl}
        add_vec("add",          6'h00, 6'h20, 1'b0, 0, 0, mk_cnt(3, 1, 1, 1, 0, 0, 3'b110));
        add_vec("sub_fwait1",   6'h00, 6'h22, 1'b0, 1, 0, mk_cnt(3, 1, 1, 1, 0, 0, 3'b111));
        add_vec("and",          6'h00, 6'h24, 1'b1, 0, 0, mk_cnt(3, 1, 1, 1, 0, 0, 3'b100));
        add_vec("or",           6'h00, 6'h25, 1'b0, 0, 0, mk_cnt(3, 1, 1, 1, 0, 0, 3'b101));
        add_vec("lw_dwait2",    6'h23, 6'h11, 1'b0, 0, 2, mk_cnt(6, 1, 1, 1, 0, 0, 3'b000));
        add_vec("sw",           6'h2B, 6'h00, 1'b0, 0, 0, mk_cnt(3, 1, 0, 1, 0, 0, 3'b000));
        add_vec("beq_taken",    6'h04, 6'h00, 1'b1, 0, 0, mk_cnt(2, 1, 0, 2, 0, 0, 3'b000));
        add_vec("beq_not",      6'h04, 6'h00, 1'b0, 0, 0, mk_cnt(2, 1, 0, 1, 0, 0, 3'b000));
        add_vec("j",            6'h02, 6'h00, 1'b0, 0, 0, mk_cnt(2, 1, 0, 2, 0, 0, 3'b000));
        add_vec("addi",         6'h08, 6'h00, 1'b0, 0, 0, mk_cnt(3, 1, 1, 1, 0, 0, 3'b000));
        add_vec("illegal_op",   6'h3F, 6'h20, 1'b0, 0, 0, mk_cnt(1, 1, 0, 1, 1, 0, 3'b000));
        add_vec("illegal_fn",   6'h00, 6'h00, 1'b0, 0, 0, mk_cnt(2, 1, 0, 1, 1, 0, 3'b100));
        add_vec("fetch_tmo",    6'h00, 6'h20, 1'b0, 5, 0, mk_cnt(0, 0, 0, 0, 0, 1, 3'b000));
        add_vec("fetch_at_lim", 6'h00, 6'h20, 1'b0, 4, 0, mk_cnt(3, 1, 1, 1, 0, 0, 3'b110));
        add_vec("lw_tmo",       6'h23, 6'h00, 1'b0, 0, 5, mk_cnt(7, 1, 0, 1, 0, 1, 3'b000));
        add_vec("sw_at_lim",    6'h2B, 6'h00, 1'b0, 0, 4, mk_cnt(7, 1, 0, 1, 0, 0, 3'b000));

        Rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b1; Opcode = 6'h00; Funct = 6'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("reset_outputs", i, sample(), '0);
        end
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        foreach (vq[i]) begin
            build(vq[i].op, vq[i].fn, vq[i].zero, vq[i].fw, vq[i].dw);
            run_q(vq[i].name, vq[i].op, vq[i].fn, got);
            checks++;
            if (got !== vq[i].exp) begin
                failures++;
                $display("FAIL %s counts: got %h expected %h", vq[i].name, got, vq[i].exp);
            end
        end

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h08;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                default: fn = 6'($urandom);
            endcase
            build(op, fn, rb(),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 2)));
            run_q("random", op, fn, got);
        end

        // Asynchronous reset while lw waits in MEMRD, then no writeback after release.
        Opcode = 6'h23; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b1;
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        MemReady = 1'b0;
        #2;
        e = blank(3); e.mrd = 1'b1; e.iord = 1'b1;
        chk("mid_memrd", 0, sample(), e);
        Rst_n = 1'b0;
        #1;
        chk("async_reset", 0, sample(), '0);
        @(posedge Clk);
        #1;
        chk("reset_hold", 0, sample(), '0);
        Rst_n = 1'b1;
        e = blank(0); e.mrd = 1'b1; e.srcb = 2'b01; e.alu = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("post_release", i, sample(), e);
            @(posedge Clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
